// File: rtl/safety_pkg.sv
// Shared types and constants for the horn DAC link and the safety level transfer.
package safety_pkg;

  // Word width shared with the horn transmitter.
  localparam int unsigned HORN_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    FULL    = 2'd2,
    OVERRUN = 2'd3
  } rx_state_e;

  // Receiver state implied by a captured-bit count.
  function automatic rx_state_e count_state(input int unsigned cnt, input int unsigned width);
    if (cnt == 0) begin
      return IDLE;
    end else if (cnt < width) begin
      return SHIFT;
    end else if (cnt == width) begin
      return FULL;
    end else begin
      return OVERRUN;
    end
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous wire with registered edge pulses.
// The level output is taken from the edge-detect flop so it lines up with the pulses.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchronizer chain, delayed copy and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~last_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & last_q;
    end
  end

  assign level = last_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/shiftin.sv
// Serial-to-parallel receiver for the horn DAC shift-register link.
// Captures bits on shift-clock falls, publishes the frame on the latch rise and
// pulses frameerror for short/long frames or a stalled link.
module shiftin
  import safety_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = HORN_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  INPUTCLOCK,
  input  logic                  RESET_N,
  input  logic                  serialinput,
  input  logic                  shiftclock,
  input  logic                  registerlatch,
  output logic [DATA_WIDTH-1:0] paralleloutput,
  output logic                  datavalid,
  output logic                  frameerror
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 2);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_WIDTH + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic data_lvl;
  logic data_rise;
  logic data_fall;
  logic sclk_lvl;
  logic sclk_rise;
  logic sclk_fall;
  logic latch_lvl;
  logic latch_rise;
  logic latch_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (INPUTCLOCK),
    .rst_n (RESET_N),
    .din   (serialinput),
    .level (data_lvl),
    .rise  (data_rise),
    .fall  (data_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (INPUTCLOCK),
    .rst_n (RESET_N),
    .din   (shiftclock),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk   (INPUTCLOCK),
    .rst_n (RESET_N),
    .din   (registerlatch),
    .level (latch_lvl),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  // Only the data level, shift-clock fall and latch rise are consumed.
  logic unused_sync;
  assign unused_sync = ^{data_rise, data_fall, sclk_lvl, sclk_rise, latch_lvl, latch_fall};

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] pout_q, pout_d;
  logic                  dv_q, dv_d;
  logic                  fe_q, fe_d;

  logic [DATA_WIDTH-1:0] shreg_cap;
  logic [CW-1:0]         cnt_cap;
  rx_state_e             state_cap;
  logic                  timeout;

  // Next state: capture first, then latch (which sees the updated count), then timeout.
  always_comb begin
    shreg_cap = shreg_q;
    cnt_cap   = bitcnt_q;
    if (sclk_fall) begin
      shreg_cap = {data_lvl, shreg_q[DATA_WIDTH-1:1]};
      if (bitcnt_q != CNT_MAX) begin
        cnt_cap = bitcnt_q + 1'b1;
      end
    end
    state_cap = count_state(int'(cnt_cap), DATA_WIDTH);
    // A capture edge restarts the silence window, so it also cancels a timeout.
    timeout   = (state_q != IDLE) && (tmo_q == TMO_LAST) && !sclk_fall;

    state_d  = state_cap;
    shreg_d  = shreg_cap;
    bitcnt_d = cnt_cap;
    tmo_d    = '0;
    pout_d   = pout_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;

    if (latch_rise) begin
      if (state_cap == FULL) begin
        pout_d = shreg_cap;
        dv_d   = 1'b1;
      end else begin
        fe_d = 1'b1;
      end
      state_d  = IDLE;
      shreg_d  = '0;
      bitcnt_d = '0;
    end else if (timeout) begin
      fe_d     = 1'b1;
      state_d  = IDLE;
      shreg_d  = '0;
      bitcnt_d = '0;
    end else if (state_cap != IDLE && !sclk_fall) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Receiver state and output registers.
  always_ff @(posedge INPUTCLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      tmo_q    <= '0;
      pout_q   <= '0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      tmo_q    <= tmo_d;
      pout_q   <= pout_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
    end
  end

  assign paralleloutput = pout_q;
  assign datavalid      = dv_q;
  assign frameerror     = fe_q;

endmodule

// File: tb/tb_shiftin.sv
// Directed bench for shiftin: expected output events go into a scoreboard queue when a frame
// is sent and are popped by a monitor whenever datavalid or frameerror pulses.
module tb_shiftin;

  localparam int unsigned W  = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned TO = 4096;

  logic         clk;
  logic         rst_n;
  logic         sdata;
  logic         sclk;
  logic         latch;
  logic [W-1:0] pout;
  logic         dv;
  logic         fe;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit           is_err;
    logic [W-1:0] value;
  } exp_t;

  exp_t sb[$];

  shiftin #(
    .DATA_WIDTH     (W),
    .SYNC_STAGES    (SS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .INPUTCLOCK     (clk),
    .RESET_N        (rst_n),
    .serialinput    (sdata),
    .shiftclock     (sclk),
    .registerlatch  (latch),
    .paralleloutput (pout),
    .datavalid      (dv),
    .frameerror     (fe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit is_err, input logic [W-1:0] value);
    exp_t e;
    e.is_err = is_err;
    e.value  = value;
    sb.push_back(e);
  endtask

  // Shift n bits LSB first; data launched with the rising shift clock, sampled on the fall.
  task automatic send_bits(input logic [15:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      sdata = data[i];
      sclk  = 1'b1;
      cycles(8);
      sclk  = 1'b0;
      cycles(8);
    end
  endtask

  task automatic do_latch();
    latch = 1'b1;
    cycles(6);
    latch = 1'b0;
    cycles(8);
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (dv || fe)) begin
      chk("dv_fe_exclusive", {31'd0, dv & fe}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, dv, fe}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, dv, fe}, e.is_err ? 32'd1 : 32'd2);
        chk("pulse_value", {24'd0, pout}, {24'd0, e.value});
      end
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    sdata = 1'b0;
    sclk  = 1'b0;
    latch = 1'b0;
    #1;
    chk("reset_pout", {24'd0, pout}, 32'd0);
    chk("reset_dv", {31'd0, dv}, 32'd0);
    chk("reset_fe", {31'd0, fe}, 32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(5);

    // Clean frame with latency measurement.
    push(1'b0, 8'hA5);
    send_bits(16'h00A5, 8);
    latch = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (dv && lat == 0) lat = k;
    end
    chk("latency", lat, SS + 2);
    latch = 1'b0;
    cycles(8);
    chk("clean_out", {24'd0, pout}, 32'h0000_00A5);
    chk("clean_sb", sb.size(), 32'd0);

    // Short frame.
    push(1'b1, 8'hA5);
    send_bits(16'h007F, 7);
    do_latch();
    chk("short_out", {24'd0, pout}, 32'h0000_00A5);
    chk("short_sb", sb.size(), 32'd0);

    // Overrun, then clean 0x3C.
    push(1'b1, 8'hA5);
    send_bits(16'h01FF, 9);
    do_latch();
    chk("overrun_out", {24'd0, pout}, 32'h0000_00A5);
    chk("overrun_sb", sb.size(), 32'd0);
    push(1'b0, 8'h3C);
    send_bits(16'h003C, 8);
    do_latch();
    chk("after_overrun_out", {24'd0, pout}, 32'h0000_003C);
    chk("after_overrun_sb", sb.size(), 32'd0);

    // Timeout after 3 bits, then 0x81.
    push(1'b1, 8'h3C);
    send_bits(16'h0005, 3);
    cycles(4000);
    chk("timeout_not_early", sb.size(), 32'd1);
    cycles(200);
    chk("timeout_fired", sb.size(), 32'd0);
    push(1'b0, 8'h81);
    send_bits(16'h0081, 8);
    do_latch();
    chk("after_timeout_out", {24'd0, pout}, 32'h0000_0081);
    chk("after_timeout_sb", sb.size(), 32'd0);

    // Reset mid-frame.
    send_bits(16'h0015, 5);
    rst_n = 1'b0;
    #1;
    chk("midreset_pout", {24'd0, pout}, 32'd0);
    chk("midreset_dv", {31'd0, dv}, 32'd0);
    chk("midreset_fe", {31'd0, fe}, 32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
    chk("postreset_pout", {24'd0, pout}, 32'd0);
    push(1'b0, 8'hFF);
    send_bits(16'h00FF, 8);
    do_latch();
    chk("after_reset_out", {24'd0, pout}, 32'h0000_00FF);
    chk("after_reset_sb", sb.size(), 32'd0);

    // 8th shift-clock fall coincident with latch rise.
    push(1'b0, 8'h5A);
    send_bits(16'h005A, 7);
    sdata = 1'b0;
    sclk  = 1'b1;
    cycles(8);
    sclk  = 1'b0;
    latch = 1'b1;
    cycles(6);
    latch = 1'b0;
    cycles(12);
    chk("coincident_out", {24'd0, pout}, 32'h0000_005A);
    chk("coincident_sb", sb.size(), 32'd0);

    cycles(20);
    chk("final_sb", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
